// File: rtl/bridge_pkg.sv
// Shared constants for the CPU data-bus bridge: peripheral address map,
// seven-segment glyph table and a small address-match helper.
package bridge_pkg;

    // Upper 20 address bits that select the peripheral page
    localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

    // Word addresses of the peripheral registers
    localparam logic [31:0] DISP_ADDR  = 32'hFFFF_F000;
    localparam logic [31:0] TIMER_ADDR = 32'hFFFF_F020;
    localparam logic [31:0] LED_ADDR   = 32'hFFFF_F060;
    localparam logic [31:0] SW_ADDR    = 32'hFFFF_F070;
    localparam logic [31:0] BTN_ADDR   = 32'hFFFF_F078;

    // Active-low {dp,g,f,e,d,c,b,a} glyphs for hex digits 0..F, dp off
    localparam logic [7:0] SEG_GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Word-offset match inside the peripheral page; byte lanes are ignored
    function automatic logic reg_match(input logic [11:2] offset, input logic [31:0] reg_addr);
        return offset == reg_addr[11:2];
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner. Each digit stays lit for
// SCAN_DIV clocks; the segment pattern follows the live display value so a
// register update shows up on the current digit without restarting the scan.
module seg_scan
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] value,
    output logic [7:0]  dig_en,
    output logic [7:0]  dn_seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_cnt_reg;
    logic [2:0]    digit_reg;
    logic [3:0]    nibble [8];

    // Dwell counter per digit; digit index advances (and wraps 7->0) at dwell end
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            scan_cnt_reg <= '0;
            digit_reg    <= 3'd0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            digit_reg    <= digit_reg + 3'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + CW'(1);
        end
    end

    // Split the display word into its eight hex digits
    for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
        assign nibble[gi] = value[4*gi +: 4];
    end

    // Active-low one-cold digit enable and glyph of the selected nibble
    always_comb begin
        dig_en = ~(8'b1 << digit_reg);
        dn_seg = SEG_GLYPH[nibble[digit_reg]];
    end

endmodule

// File: rtl/bus_bridge.sv
// Data-bus bridge for the single-cycle core: routes each access either to
// the data RAM or to the peripheral page (display, timer, LEDs, switches,
// buttons) and returns read data combinationally in the same cycle.
module bus_bridge
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int TIMER_DIV = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] bus_addr,
    input  logic        bus_wen,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dn_seg
);

    localparam int DW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TIMER_DIV - 1);

    logic        periph;
    logic        sel_disp;
    logic        sel_timer;
    logic        sel_led;
    logic        sel_sw;
    logic        sel_btn;
    logic        addr_lsb_unused;

    logic [31:0] disp_reg;
    logic [23:0] led_reg;
    logic [31:0] timer_reg;
    logic [DW-1:0] div_reg;
    logic [23:0] sw_meta_reg;
    logic [23:0] sw_sync_reg;
    logic [4:0]  btn_meta_reg;
    logic [4:0]  btn_sync_reg;

    // Byte lanes carry no meaning: every access is a full word
    assign addr_lsb_unused = ^bus_addr[1:0];

    // Address decode: peripheral page versus RAM, then register select
    always_comb begin
        periph    = (bus_addr[31:12] == PERIPH_BASE);
        sel_disp  = periph && reg_match(bus_addr[11:2], DISP_ADDR);
        sel_timer = periph && reg_match(bus_addr[11:2], TIMER_ADDR);
        sel_led   = periph && reg_match(bus_addr[11:2], LED_ADDR);
        sel_sw    = periph && reg_match(bus_addr[11:2], SW_ADDR);
        sel_btn   = periph && reg_match(bus_addr[11:2], BTN_ADDR);
    end

    // RAM port is a pass-through; peripheral-page writes never reach it
    always_comb begin
        dram_addr  = bus_addr[15:2];
        dram_wdata = bus_wdata;
        dram_wen   = bus_wen & ~periph;
    end

    // Read mux; unmapped peripheral addresses return zero
    always_comb begin
        bus_rdata = 32'h0;
        if (!periph) begin
            bus_rdata = dram_rdata;
        end else if (sel_disp) begin
            bus_rdata = disp_reg;
        end else if (sel_timer) begin
            bus_rdata = timer_reg;
        end else if (sel_led) begin
            bus_rdata = {8'h0, led_reg};
        end else if (sel_sw) begin
            bus_rdata = {8'h0, sw_sync_reg};
        end else if (sel_btn) begin
            bus_rdata = {27'h0, btn_sync_reg};
        end
    end

    // Writable display and LED registers
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            disp_reg <= 32'h0;
            led_reg  <= 24'h0;
        end else if (bus_wen) begin
            if (sel_disp) disp_reg <= bus_wdata;
            if (sel_led)  led_reg  <= bus_wdata[23:0];
        end
    end

    // Free-running timer; a bus write takes priority over a coincident tick
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            timer_reg <= 32'h0;
            div_reg   <= '0;
        end else if (bus_wen && sel_timer) begin
            timer_reg <= bus_wdata;
            div_reg   <= '0;
        end else if (div_reg == DIV_LAST) begin
            timer_reg <= timer_reg + 32'd1;
            div_reg   <= '0;
        end else begin
            div_reg   <= div_reg + DW'(1);
        end
    end

    // Two-flop synchronisers for the asynchronous switch and button inputs
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sw_meta_reg  <= 24'h0;
            sw_sync_reg  <= 24'h0;
            btn_meta_reg <= 5'h0;
            btn_sync_reg <= 5'h0;
        end else begin
            sw_meta_reg  <= sw;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= button;
            btn_sync_reg <= btn_meta_reg;
        end
    end

    assign led = led_reg;

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .value   (disp_reg),
        .dig_en  (dig_en),
        .dn_seg  (dn_seg)
    );

endmodule

// File: tb/tb_bus_bridge.sv
// Randomised scoreboard bench for bus_bridge. The stimulus process drives one
// bus access per cycle and queues the expected outputs from a cycle-count
// based reference model; a negedge monitor pops and compares them.
module tb_bus_bridge;

    localparam int SD = 4;
    localparam int TD = 2;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  button;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dn_seg;

    bus_bridge #(.SCAN_DIV(SD), .TIMER_DIV(TD)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .bus_addr   (bus_addr),
        .bus_wen    (bus_wen),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .dn_seg     (dn_seg)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;   // 0 rdata 1 led 2 dig_en 3 dn_seg 4 dram_wen 5 dram_addr 6 dram_wdata
        logic [31:0] exp;
        logic [31:0] addr;
    } chk_t;

    chk_t q[$];
    int total = 0;
    int bad   = 0;

    function automatic string kind_name(input int k);
        case (k)
            0: return "rdata";
            1: return "led";
            2: return "dig_en";
            3: return "dn_seg";
            4: return "dram_wen";
            5: return "dram_addr";
            default: return "dram_wdata";
        endcase
    endfunction

    function automatic logic [31:0] actual_of(input int k);
        case (k)
            0: return bus_rdata;
            1: return {8'h0, led};
            2: return {24'h0, dig_en};
            3: return {24'h0, dn_seg};
            4: return {31'h0, dram_wen};
            5: return {18'h0, dram_addr};
            default: return dram_wdata;
        endcase
    endfunction

    // Monitor: everything queued for this cycle is compared mid-cycle
    always @(negedge cpu_clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c   = q.pop_front();
            act = actual_of(c.kind);
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s addr=%08h got=%08h want=%08h", kind_name(c.kind), c.addr, act, c.exp);
            end
        end
    end

    // ---------------- reference model ----------------
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int          cyc;        // clock edges since reset release
    logic [31:0] m_disp;
    logic [23:0] m_led;
    logic [31:0] m_tbase;    // timer value loaded at edge m_tload
    int          m_tload;
    logic [23:0] sw_at[$];   // switch value driven after edge n
    logic [4:0]  btn_at[$];
    logic [23:0] cur_sw;
    logic [4:0]  cur_btn;

    function automatic bit is_periph(input logic [31:0] a);
        return a[31:12] == 20'hFFFFF;
    endfunction

    function automatic logic [31:0] m_timer();
        return m_tbase + 32'((cyc - m_tload) / TD);
    endfunction

    function automatic int m_digit();
        return (cyc / SD) % 8;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [31:0] ram);
        logic [11:0] off;
        if (!is_periph(a)) return ram;
        off = {a[11:2], 2'b00};
        case (off)
            12'h000: return m_disp;
            12'h020: return m_timer();
            12'h060: return {8'h0, m_led};
            12'h070: return (cyc >= 2) ? {8'h0, sw_at[cyc-2]} : 32'h0;
            12'h078: return (cyc >= 2) ? {27'h0, btn_at[cyc-2]} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] e, input logic [31:0] a);
        chk_t c;
        c.kind = k; c.exp = e; c.addr = a;
        q.push_back(c);
    endtask

    task automatic push_outputs(input logic [31:0] a);
        logic [3:0] nib;
        nib = m_disp[4*m_digit() +: 4];
        push(1, {8'h0, m_led}, a);
        push(2, {24'h0, ~(8'b1 << m_digit())}, a);
        push(3, {24'h0, GLYPH[nib]}, a);
    endtask

    // One bus cycle: drive, queue expectations, clock, apply committed write
    task automatic step(input logic [31:0] a, input bit wen, input logic [31:0] wd);
        bus_addr   = a;
        bus_wen    = wen;
        bus_wdata  = wd;
        sw         = cur_sw;
        button     = cur_btn;
        dram_rdata = $urandom;
        push(0, m_read(a, dram_rdata), a);
        push(4, {31'h0, wen && !is_periph(a)}, a);
        push(5, {18'h0, a[15:2]}, a);
        push(6, wd, a);
        push_outputs(a);
        sw_at.push_back(cur_sw);
        btn_at.push_back(cur_btn);
        $display("cyc=%0d addr=%08h wen=%0d wdata=%08h sw=%06h btn=%02h", cyc, a, wen, wd, cur_sw, cur_btn);
        @(posedge cpu_clk);
        if (wen && is_periph(a)) begin
            case ({a[11:2], 2'b00})
                12'h000: m_disp = wd;
                12'h020: begin m_tbase = wd; m_tload = cyc + 1; end
                12'h060: m_led = wd[23:0];
                default: ;
            endcase
        end
        cyc++;
        #1;
    endtask

    // Hold reset for 3 edges, check reset outputs, release between edges
    task automatic do_reset();
        cpu_rst   = 1'b0;
        bus_addr  = 32'hFFFF_F020;
        bus_wen   = 1'b0;
        bus_wdata = 32'h0;
        dram_rdata = 32'h0;
        repeat (3) @(posedge cpu_clk);
        #1;
        m_disp = 32'h0; m_led = 24'h0; m_tbase = 32'h0; m_tload = 0; cyc = 0;
        sw_at.delete(); btn_at.delete();
        push(0, 32'h0, bus_addr);
        push_outputs(bus_addr);
        $display("reset check");
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 8))
            0: a = 32'hFFFF_F000;
            1: a = 32'hFFFF_F020;
            2: a = 32'hFFFF_F060;
            3: a = 32'hFFFF_F070;
            4: a = 32'hFFFF_F078;
            5: a = 32'hFFFF_F040;
            6: a = {20'hFFFFF, 12'($urandom)};
            default: a = {$urandom_range(0, 32'hFFFF_EFFF)};
        endcase
        a[1:0] = 2'($urandom);
        return a;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        cur_sw  = 24'h0;
        cur_btn = 5'h0;
        sw      = 24'h0;
        button  = 5'h0;
        do_reset();

        // timer: 3 after 6 edges at TIMER_DIV=2
        repeat (6) step(32'h0000_0010, 1'b0, 32'h0);
        step(32'hFFFF_F020, 1'b0, 32'h0);

        // RAM path and LED write keeping RAM quiet
        step(32'h0000_0104, 1'b1, 32'hDEAD_BEEF);
        step(32'h0000_0104, 1'b0, 32'h0);
        step(32'hFFFF_F060, 1'b1, 32'hFFA5_A5A5);
        step(32'hFFFF_F060, 1'b0, 32'h0);

        // switch synchroniser latency
        cur_sw = 24'h00F00F;
        cur_btn = 5'h15;
        repeat (3) step(32'hFFFF_F070, 1'b0, 32'h0);
        step(32'hFFFF_F078, 1'b0, 32'h0);

        // display scan over a full rotation and a bit
        step(32'hFFFF_F000, 1'b1, 32'h7654_3210);
        repeat (36) step(32'hFFFF_F000, 1'b0, 32'h0);

        // timer wrap and write coincident with a tick
        step(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFF);
        repeat (3) step(32'hFFFF_F020, 1'b0, 32'h0);
        if (((cyc + 1) % TD) != 0) step(32'h0000_0000, 1'b0, 32'h0);
        step(32'hFFFF_F020, 1'b1, 32'h1234_5678);
        step(32'hFFFF_F020, 1'b0, 32'h0);

        // unmapped and read-only writes
        step(32'hFFFF_F040, 1'b1, 32'hCAFE_F00D);
        step(32'hFFFF_F040, 1'b0, 32'h0);
        step(32'hFFFF_F070, 1'b1, 32'h00FF_FFFF);
        step(32'hFFFF_F070, 1'b0, 32'h0);

        // reset in the middle of a scan and count
        step(32'hFFFF_F000, 1'b1, 32'hFEDC_BA98);
        repeat (5) step(32'hFFFF_F020, 1'b0, 32'h0);
        do_reset();
        repeat (3) step(32'hFFFF_F000, 1'b0, 32'h0);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) cur_sw  = 24'($urandom);
            if ($urandom_range(0, 7) == 0) cur_btn = 5'($urandom);
            step(rand_addr(), bit'($urandom_range(0, 1)), $urandom);
        end

        // drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge cpu_clk);
        @(negedge cpu_clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
